// File: rtl/sram_bank_pipe.sv
// ----------------------------------------------------------------------------
// sram_bank_pipe
//   Single-port synchronous SRAM bank model placed between the cache
//   controller and one data or tag array. Requests use a req/ready handshake;
//   writes honour per-byte enables; reads return through a RD_LATENCY-deep
//   register pipeline with a one-cycle o_rvalid strobe. After reset an
//   optional hardware sweep zeroes every word before requests are accepted.
//
// Ports
//   i_ck        clock, all state changes on the rising edge
//   i_rst       synchronous active-high reset
//   i_req       request valid
//   i_we        1 = write, 0 = read (qualified by i_req)
//   i_addr      word address
//   i_be        byte enables for writes (ignored on reads)
//   i_data_w    write data
//   o_ready     bank accepts a request this cycle
//   o_rvalid    read data valid, one pulse per accepted read
//   o_data_r    registered read data, holds when o_rvalid = 0
//   o_busy_clr  clear sweep in progress
// ----------------------------------------------------------------------------
module sram_bank_pipe #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int RD_LATENCY     = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  i_ck,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [BE_WIDTH-1:0]   i_be,
  input  logic [DATA_WIDTH-1:0] i_data_w,
  output logic                  o_ready,
  output logic                  o_rvalid,
  output logic [DATA_WIDTH-1:0] o_data_r,
  output logic                  o_busy_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  // Elaboration-time parameter legality checks.
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("sram_bank_pipe: RD_LATENCY must be in 1..4");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("sram_bank_pipe: DATA_WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    accept;
  logic                    wr_accept;
  logic                    rd_accept;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   pipe_data [RD_LATENCY];
  logic [RD_LATENCY-1:0]   pipe_vld;

  // --------------------------------------------------------------------------
  // Control FSM: next state and Moore-style outputs.
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    o_ready    = 1'b0;
    o_busy_clr = 1'b0;
    case (state)
      ST_CLEAR: begin
        o_busy_clr = 1'b1;
        if (clr_cnt == CNT_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // Reset has priority over any request, so never advertise ready
        // during a reset cycle.
        o_ready = ~i_rst;
      end
    endcase
  end

  assign accept    = i_req & o_ready;
  assign wr_accept = accept & i_we;
  assign rd_accept = accept & ~i_we;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage array: clear sweep or byte-enabled write.
  // --------------------------------------------------------------------------
  // NOTE: the array has no reset branch; only the sweep (or real writes)
  // initialise it, which keeps it mappable onto an SRAM macro.
  always_ff @(posedge i_ck) begin
    if (!i_rst) begin
      if (state == ST_CLEAR) begin
        mem[clr_cnt] <= '0;
      end else if (wr_accept) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (i_be[b]) begin
            mem[i_addr][8*b +: 8] <= i_data_w[8*b +: 8];
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline. Stage 0 samples the array at the accept edge, so a write
  // to the same address on that edge or later cannot disturb the read.
  // Data stages load only when a valid moves in, so the last stage (and
  // therefore o_data_r) holds between responses.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_accept;
      if (rd_accept) begin
        pipe_data[0] <= mem[i_addr];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign o_rvalid = pipe_vld[RD_LATENCY-1];
  assign o_data_r = pipe_data[RD_LATENCY-1];

endmodule

// File: tb/tb_sram_bank_pipe.sv
// ----------------------------------------------------------------------------
// tb_sram_bank_pipe
//   Directed-vector bench for sram_bank_pipe (ADDR_WIDTH=4, DATA_WIDTH=32,
//   RD_LATENCY=2, CLEAR_ON_RESET=1). The driver pushes each expected read
//   response, with the negedge on which it must appear, into a scoreboard
//   queue; an independent monitor pops and compares whenever o_rvalid is
//   seen and flags missing, early, late or unexpected responses.
// ----------------------------------------------------------------------------
module tb_sram_bank_pipe;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int BW  = DW / 8;

  logic          i_ck = 1'b0;
  logic          i_rst;
  logic          i_req;
  logic          i_we;
  logic [AW-1:0] i_addr;
  logic [BW-1:0] i_be;
  logic [DW-1:0] i_data_w;
  logic          o_ready;
  logic          o_rvalid;
  logic [DW-1:0] o_data_r;
  logic          o_busy_clr;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  sram_bank_pipe #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .RD_LATENCY     (LAT),
    .CLEAR_ON_RESET (1)
  ) dut (
    .i_ck       (i_ck),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_addr     (i_addr),
    .i_be       (i_be),
    .i_data_w   (i_data_w),
    .o_ready    (o_ready),
    .o_rvalid   (o_rvalid),
    .o_data_r   (o_data_r),
    .o_busy_clr (o_busy_clr)
  );

  always #5 i_ck = ~i_ck;

  always @(posedge i_ck) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge i_ck) begin
    exp_t e;
    if (o_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", o_data_r, e.data);
        check("rvalid_cycle", edge_cnt, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
      e = sb.pop_front();
      check("missing_rvalid", edge_cnt, e.due);
    end
  end

  // Driver tasks: called at a negedge, apply one request for one cycle.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] be);
    check("ready_on_write", {31'd0, o_ready}, 32'd1);
    i_req = 1'b1; i_we = 1'b1; i_addr = a; i_data_w = d; i_be = be;
    @(negedge i_ck);
    i_req = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    exp_t e;
    check("ready_on_read", {31'd0, o_ready}, 32'd1);
    i_req = 1'b1; i_we = 1'b0; i_addr = a; i_be = '0;
    e.data = exp;
    e.due  = edge_cnt + LAT;
    sb.push_back(e);
    @(negedge i_ck);
    i_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge i_ck);
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
  endtask

  // One-cycle reset pulse followed by measurement of the clear sweep.
  // With hold_req, a write to addr 7 is held for the whole sweep and dropped
  // on the first cycle o_ready is seen high.
  task automatic reset_and_sweep(input bit hold_req);
    int n       = 0;
    int gap     = 0;
    int rv_seen = 0;
    i_req = 1'b0;
    i_rst = 1'b1;
    @(negedge i_ck);
    i_rst = 1'b0;
    sb.delete();
    check("rst_ready",    {31'd0, o_ready},    32'd0);
    check("rst_rvalid",   {31'd0, o_rvalid},   32'd0);
    check("rst_data_r",   o_data_r,            32'd0);
    check("rst_busy_clr", {31'd0, o_busy_clr}, 32'd1);
    if (hold_req) begin
      i_req = 1'b1; i_we = 1'b1; i_addr = 4'd7; i_data_w = 32'h55; i_be = '1;
    end
    while (o_ready !== 1'b1 && n < 100) begin
      if (o_busy_clr !== 1'b1) gap++;
      if (o_rvalid !== 1'b0) rv_seen++;
      n++;
      @(negedge i_ck);
    end
    i_req = 1'b0;
    check("sweep_cycles",   n,                   32'd16);
    check("sweep_busy_gap", gap,                 32'd0);
    check("sweep_rvalid",   rv_seen,             32'd0);
    check("post_sweep_busy", {31'd0, o_busy_clr}, 32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, n_errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_be = '0; i_data_w = '0;
    repeat (2) @(negedge i_ck);

    // 1. Reset sweep, then every word reads as zero.
    reset_and_sweep(1'b0);
    for (int a = 0; a < 16; a++) do_read(a[AW-1:0], 32'h0000_0000);
    wait_drain();

    // 2. Write then read on the next cycle; response two cycles later.
    do_write(4'd3, 32'hDEAD_BEEF, 4'hF);
    do_read(4'd3, 32'hDEAD_BEEF);
    wait_drain();
    repeat (2) @(negedge i_ck);
    check("data_r_hold", o_data_r, 32'hDEAD_BEEF);

    // i_be = 0 is a legal no-op write.
    do_write(4'd3, 32'h0000_0000, 4'h0);
    do_read(4'd3, 32'hDEAD_BEEF);
    wait_drain();

    // 3. Byte enables.
    do_write(4'd5, 32'h1122_3344, 4'hF);
    do_write(4'd5, 32'hAABB_CCDD, 4'b0101);
    do_read(4'd5, 32'h11BB_33DD);
    wait_drain();

    // 4. Pipelined reads at both address extremes and read-old.
    do_write(4'd0,  32'h0000_000A, 4'hF);
    do_write(4'd15, 32'h0000_000F, 4'hF);
    do_read(4'd0,  32'h0000_000A);
    do_read(4'd15, 32'h0000_000F);
    do_write(4'd0, 32'h0000_000B, 4'hF);
    do_read(4'd0,  32'h0000_000B);
    wait_drain();

    // 5 + 6. Read in flight, reset next cycle, request held during sweep.
    i_req = 1'b1; i_we = 1'b0; i_addr = 4'd3; i_be = '0;
    @(negedge i_ck);
    reset_and_sweep(1'b1);
    do_read(4'd7, 32'h0000_0000);
    do_read(4'd3, 32'h0000_0000);
    do_read(4'd5, 32'h0000_0000);
    wait_drain();
    repeat (3) @(negedge i_ck);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
